par_to_serial_8_1: RTL and testbench
====================================

Name: par_to_serial_8_1

Overview:
Downstream serializer for the 32:8 byte stream. It accepts bytes over a valid/ready handshake and emits them MSB-first, one bit per clock, in fixed 8-cycle symbol slots. Slots with no data carry the idle/comma symbol 0xBC. After every reset it sends a fixed number of idle symbols, so the receiver can align, before it accepts any data.

Parameters:
SYNC_SYMBOLS, 4, number of idle symbols sent after reset before data is accepted (legal range 1..15)
IDLE_SYM, 8'hBC, symbol sent in every slot without data

Ports:
clk_32f  input  1  bit clock; one serial bit per rising edge
reset_L  input  1  synchronous reset, active-low, sampled on the rising edge of clk_32f
data_in  input  8  byte to serialize (upstream data_out)
valid_in  input  1  data_in is valid (upstream valid_out)
ready_out  output  1  block can take a byte this cycle; transfer occurs when valid_in & ready_out at a rising edge
data_out  output  1  serial bit = shift register MSB
sync_done  output  1  high when state is ACTIVE
out_is_data  output  1  high while the symbol on data_out is a data byte (not IDLE_SYM)

Behaviour:
- Registers: shreg[7:0], bit_cnt[2:0], sym_cnt[3:0], hold[7:0], hold_valid, state, out_is_data.
- Reset (reset_L=0 at an edge): shreg=0, bit_cnt=0, sym_cnt=0, hold=0, hold_valid=0, out_is_data=0, state=RESET.
- Output values while in reset: data_out=0, sync_done=0, ready_out=0.
- Reset asserted mid-symbol or mid-byte: the symbol is truncated at that edge, a held byte is discarded, and the full sync sequence restarts.
- States: RESET, SYNC, ACTIVE.
- RESET, first edge with reset_L=1 (E0): state goes to SYNC, shreg loads IDLE_SYM, bit_cnt=0, sym_cnt=0.
- Every later edge, symbol boundary (bit_cnt==7): load the next symbol into shreg and set bit_cnt=0.
- Every later edge, otherwise: shreg shifts left (zero fill) and bit_cnt increments.
- Symbol loads therefore occur at E0+8k.
- Next-symbol choice at a boundary:
  - state==ACTIVE and hold_valid: load hold, out_is_data=1, hold_valid cleared unless refilled on the same edge.
  - otherwise: load IDLE_SYM, out_is_data=0.
- SYNC: sym_cnt increments at each boundary. At the boundary where sym_cnt==SYNC_SYMBOLS-1, state goes to ACTIVE; that slot still loads IDLE_SYM.
- With SYNC_SYMBOLS=4 the state becomes ACTIVE at E0+32.
- ready_out (combinational) = (state==ACTIVE) & (!hold_valid | bit_cnt==7).
- Accept into an empty hold: hold<=data_in, hold_valid<=1.
- Accept on the same edge the hold drains to shreg: hold takes the new byte and hold_valid stays 1. No bubble, so back-to-back bytes go out in consecutive slots.
- ready_out=0 in SYNC and RESET; valid_in is ignored there and no byte is lost or queued.
- Latency: a byte accepted on edge A is loaded at the first boundary edge strictly after A. Its MSB appears on data_out in the following cycle; its LSB 7 cycles later.
- Sustained throughput: 1 byte per 8 clk_32f cycles, i.e. one per clk_4f cycle of the upstream clock ratio.
- Upstream stall (valid_in=0 at a boundary with hold empty): IDLE_SYM is inserted and out_is_data=0 for that slot. The stream never stops.

Decomposition:
- Shared package: IDLE_SYM constant (8'hBC), state encodings (RESET=2'd0, SYNC=2'd1, ACTIVE=2'd2), SYMBOL_BITS=8.
- The same package is reused by the future serial-to-parallel receiver, which searches for 0xBC.
- Single flat module. The hold register plus handshake is small enough that no sub-module is warranted.

Test Plan:
- Reset 5 cycles, then release with valid_in=0 -> data_out repeats 1,0,1,1,1,1,0,0 from E0+1. ready_out=0 until E0+32, sync_done=1 from E0+32, out_is_data=0 throughout.
- After sync, present 0xA5 accepted at E0+33 -> bits 1,0,1,0,0,1,0,1 on cycles after edges E0+40..E0+47, out_is_data=1 for that slot. IDLE_SYM resumes at E0+48.
- valid_in held high with 0x01,0x02,0xFF,0x00 -> four consecutive data slots with no IDLE between them. ready_out drops after the hold fills and pulses only at bit_cnt==7.
- valid_in=1 with 0x55 during SYNC -> ready_out=0 and the byte is never emitted. The first data slot carries only bytes presented after sync_done.
- reset_L=0 for 1 cycle while 0xC3 is mid-shift at bit 3 with 0x3C held -> data_out=0 during reset, then the full 4-symbol idle sequence. Neither 0xC3's remainder nor 0x3C is ever emitted.
- Stall case: one byte 0x81, then valid_in=0 for 3 slots -> slot sequence 0x81, BC, BC, BC, with out_is_data 1,0,0,0.

Source files
------------

// File: rtl/par_to_serial_8_1_pkg.sv
// Shared symbol constants and state encoding for the 8:1 serializer and the
// matching serial-to-parallel receiver (which hunts for IDLE_SYM to align).
package par_to_serial_8_1_pkg;
  localparam int SYMBOL_BITS = 8;
  localparam logic [SYMBOL_BITS-1:0] IDLE_SYM = 8'hBC;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;
endpackage

// File: rtl/par_to_serial_8_1.sv
// Byte-to-bit serializer: MSB-first in fixed 8-cycle slots, idle/comma fill,
// and a post-reset run of idle symbols before the handshake opens.
module par_to_serial_8_1 #(
  parameter int         SYNC_SYMBOLS = 4,
  parameter logic [7:0] IDLE_SYM     = par_to_serial_8_1_pkg::IDLE_SYM
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       sync_done,
  output logic       out_is_data
);
  import par_to_serial_8_1_pkg::*;

  localparam int              CNT_W     = $clog2(SYMBOL_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(SYMBOL_BITS - 1);
  localparam logic [3:0]      LAST_SYNC = 4'(SYNC_SYMBOLS - 1);

  state_t                 state, state_n;
  logic [SYMBOL_BITS-1:0] shreg, shreg_n;
  logic [SYMBOL_BITS-1:0] hold, hold_n;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_n;
  logic [3:0]             sym_cnt, sym_cnt_n;
  logic                   hold_valid, hold_valid_n;
  logic                   is_data_n;
  logic                   boundary, accept;

  assign boundary  = (bit_cnt == BIT_LAST);
  // Hold may refill on the edge it drains, so back-to-back bytes see no bubble.
  assign ready_out = (state == ACTIVE) && (!hold_valid || boundary);
  assign accept    = valid_in && ready_out;
  assign data_out  = shreg[SYMBOL_BITS-1];
  assign sync_done = (state == ACTIVE);

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    sym_cnt_n    = sym_cnt;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    is_data_n    = out_is_data;

    if (state != SYNC && state != ACTIVE) begin
      // First edge out of reset starts the first idle slot (also recovers 2'd3).
      state_n   = SYNC;
      shreg_n   = IDLE_SYM;
      bit_cnt_n = '0;
      sym_cnt_n = '0;
      is_data_n = 1'b0;
    end else if (boundary) begin
      bit_cnt_n = '0;
      if (state == ACTIVE && hold_valid) begin
        shreg_n      = hold;
        is_data_n    = 1'b1;
        hold_valid_n = 1'b0;
      end else begin
        shreg_n   = IDLE_SYM;
        is_data_n = 1'b0;
      end
      if (state == SYNC) begin
        sym_cnt_n = sym_cnt + 4'd1;
        if (sym_cnt == LAST_SYNC) state_n = ACTIVE;
      end
    end else begin
      shreg_n   = {shreg[SYMBOL_BITS-2:0], 1'b0};
      bit_cnt_n = bit_cnt + CNT_W'(1);
    end

    if (accept) begin
      hold_n       = data_in;
      hold_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state       <= RESET;
      shreg       <= '0;
      bit_cnt     <= '0;
      sym_cnt     <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      out_is_data <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      sym_cnt     <= sym_cnt_n;
      hold        <= hold_n;
      hold_valid  <= hold_valid_n;
      out_is_data <= is_data_n;
    end
  end
endmodule

// File: tb/tb_par_to_serial_8_1.sv
// Randomized + directed bench for par_to_serial_8_1 against a slot-level model.
module tb_par_to_serial_8_1;
  localparam int         SYNC = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready_out, data_out, sync_done, out_is_data;

  int total = 0;
  int bad   = 0;

  par_to_serial_8_1 #(.SYNC_SYMBOLS(SYNC), .IDLE_SYM(IDLE)) dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .sync_done  (sync_done),
    .out_is_data(out_is_data)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_n counts edges since the first edge out of reset; a slot starts
  // every 8 edges, the byte queue holds at most one pending byte.
  bit         m_known = 0, m_rst = 0, m_acc = 0;
  int         m_n = -1;
  logic [7:0] m_q[$];
  logic [7:0] m_sym = 8'h00;
  bit         m_isd = 0;

  function automatic bit m_ready();
    return m_known && !m_rst && m_n >= 8 * SYNC && (m_q.size() == 0 || m_n % 8 == 7);
  endfunction

  always @(posedge clk_32f) begin
    bit acc;
    acc   = m_ready() && valid_in;
    m_acc = 0;
    if (!reset_L) begin
      m_known = 1; m_rst = 1; m_n = -1; m_q.delete(); m_sym = 8'h00; m_isd = 0;
    end else if (m_rst) begin
      m_rst = 0; m_n = 0; m_sym = IDLE; m_isd = 0;
    end else if (m_known) begin
      m_n++;
      if (m_n % 8 == 0) begin
        if (m_q.size() > 0) begin m_sym = m_q.pop_front(); m_isd = 1; end
        else begin m_sym = IDLE; m_isd = 0; end
      end
      if (acc) begin m_q.push_back(data_in); m_acc = 1; end
    end
  end

  // Observation log of the current epoch, used by the literal checks.
  logic       obs_bit[2048], obs_isd[2048], obs_rdy[2048], obs_sd[2048];
  logic [7:0] slot_sym[256];
  logic       slot_isd[256];
  int         nslots = 0;
  logic [7:0] cur = 8'h00;
  logic       cur_isd = 1'b0;

  always @(negedge clk_32f) begin
    if (m_known) begin
      if (m_rst) begin
        chk("rst_data_out", data_out, 0);
        chk("rst_sync_done", sync_done, 0);
        chk("rst_ready", ready_out, 0);
        chk("rst_is_data", out_is_data, 0);
      end else begin
        chk("data_out", data_out, m_sym[7 - (m_n % 8)]);
        chk("sync_done", sync_done, m_n >= 8 * SYNC);
        chk("ready_out", ready_out, m_ready());
        chk("out_is_data", out_is_data, m_isd);
        if (m_n == 0) nslots = 0;
        if (m_n < 2048) begin
          obs_bit[m_n] = data_out; obs_isd[m_n] = out_is_data;
          obs_rdy[m_n] = ready_out; obs_sd[m_n] = sync_done;
        end
        cur = {cur[6:0], data_out};
        if (m_n % 8 == 0) cur_isd = out_is_data;
        if (m_n % 8 == 7 && m_n / 8 < 256) begin
          slot_sym[m_n / 8] = cur; slot_isd[m_n / 8] = cur_isd; nslots = m_n / 8 + 1;
        end
      end
    end
  end

  logic [7:0] got_b[$];
  int         got_k[$];
  task automatic collect();
    got_b.delete(); got_k.delete();
    for (int k = 0; k < nslots; k++)
      if (slot_isd[k]) begin got_b.push_back(slot_sym[k]); got_k.push_back(k); end
  endtask

  task automatic tick(); @(posedge clk_32f); #1; endtask

  task automatic start(input int rc);
    reset_L = 0; valid_in = 0;
    repeat (rc) tick();
    reset_L = 1;
    tick();
  endtask

  task automatic wait_n(input int t);
    int g = 0;
    while (m_n < t && g < 4000) begin tick(); g++; end
    if (m_n < t) chk("wait_timeout", m_n, t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat, b4[4];
    int g, idx, cnt;

    // Phase 1: idle sync pattern, then one byte 0xA5 accepted at E0+33.
    start(5);
    wait_n(32);
    valid_in = 1; data_in = 8'hA5;
    tick();
    valid_in = 0;
    wait_n(50);
    pat = IDLE;
    for (int i = 0; i < 16; i++) chk("p1_idle_bit", obs_bit[i], pat[7 - (i % 8)]);
    chk("p1_rdy31", obs_rdy[31], 0);
    chk("p1_rdy32", obs_rdy[32], 1);
    chk("p1_sd31", obs_sd[31], 0);
    chk("p1_sd32", obs_sd[32], 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) cnt += int'(obs_isd[i]);
    chk("p1_no_data_in_sync", cnt, 0);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) chk("p1_a5_bit", obs_bit[40 + i], pat[7 - i]);
    chk("p1_isd40", obs_isd[40], 1);
    chk("p1_isd47", obs_isd[47], 1);
    chk("p1_isd48", obs_isd[48], 0);
    chk("p1_bit48", obs_bit[48], 1);

    // Phase 2: four back-to-back bytes with valid held high.
    b4[0] = 8'h01; b4[1] = 8'h02; b4[2] = 8'hFF; b4[3] = 8'h00;
    start(2);
    wait_n(32);
    idx = 0; g = 0; valid_in = 1; data_in = b4[0];
    while (idx < 4 && g < 200) begin
      tick(); g++;
      if (m_acc) begin idx++; if (idx < 4) data_in = b4[idx]; end
    end
    valid_in = 0;
    wait_n(80);
    collect();
    chk("p2_count", got_b.size(), 4);
    if (got_b.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("p2_byte", got_b[i], b4[i]);
      chk("p2_first_slot", got_k[0], 5);
      for (int i = 0; i < 3; i++) chk("p2_consecutive", got_k[i + 1] - got_k[i], 1);
    end

    // Phase 3: byte offered during sync must be ignored.
    start(3);
    valid_in = 1; data_in = 8'h55;
    wait_n(32);
    data_in = 8'h77;
    tick();
    valid_in = 0;
    wait_n(60);
    cnt = 0;
    for (int i = 0; i < 32; i++) cnt += int'(obs_rdy[i]);
    chk("p3_ready_in_sync", cnt, 0);
    collect();
    chk("p3_count", got_b.size(), 1);
    if (got_b.size() == 1) chk("p3_byte", got_b[0], 8'h77);

    // Phase 4: reset with 0xC3 mid-shift and 0x3C held.
    start(2);
    wait_n(32);
    valid_in = 1; data_in = 8'hC3;
    tick();
    data_in = 8'h3C;
    wait_n(40);
    valid_in = 0;
    wait_n(43);
    reset_L = 0;
    tick();
    reset_L = 1;
    tick();
    wait_n(60);
    collect();
    chk("p4_nothing_emitted", got_b.size(), 0);
    chk("p4_first_slot_idle", slot_sym[0], IDLE);
    chk("p4_sync_again", obs_sd[31], 0);

    // Phase 5: one byte then an upstream stall.
    start(2);
    wait_n(32);
    valid_in = 1; data_in = 8'h81;
    tick();
    valid_in = 0;
    wait_n(72);
    chk("p5_s0", slot_sym[5], 8'h81); chk("p5_d0", slot_isd[5], 1);
    chk("p5_s1", slot_sym[6], IDLE);  chk("p5_d1", slot_isd[6], 0);
    chk("p5_s2", slot_sym[7], IDLE);  chk("p5_d2", slot_isd[7], 0);
    chk("p5_s3", slot_sym[8], IDLE);  chk("p5_d3", slot_isd[8], 0);

    // Phase 6: random traffic with occasional mid-stream resets.
    for (int e = 0; e < 6; e++) begin
      start(int'($urandom_range(1, 3)));
      for (int c = 0; c < 400; c++) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = 8'($urandom);
        reset_L  = ($urandom_range(0, 299) != 0);
        tick();
        reset_L = 1;
      end
    end
    valid_in = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
